// File: rtl/mc_select_controller_pkg.sv
// Package mc_ctrl_pkg: shared types and constants for the multicycle select
// controller. It holds the FSM state encoding, the opcode and ALU-op constants,
// the control-vector struct passed from the encoder to the top, and the
// is_two_byte() decode helper.
// Optional feature macro: RET_STACK_EN. When it is defined, JSR/RET are real
// instructions. When it is undefined, they decode as NOP.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_F1   = 4'd1,
        S_DEC  = 4'd2,
        S_F2   = 4'd3,
        S_RD   = 4'd4,
        S_WB   = 4'd5,
        S_WR   = 4'd6,
        S_JMP  = 4'd7,
`ifdef RET_STACK_EN
        S_RET  = 4'd8,
`endif
        S_HALT = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JSR = 4'h9;
    localparam logic [3:0] OP_RET = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef struct packed {
        logic       pc_sel_inc;
        logic       pc_sel_jmp;
        logic       pc_sel_ret;
        logic       pc_ld;
        logic       addr_sel_pc;
        logic       addr_sel_ir;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_hi_ld;
        logic       ir_lo_ld;
        logic       mdr_ld;
        logic       acc_sel_alu;
        logic       acc_sel_mem;
        logic       acc_ld;
        logic [1:0] alu_op;
        logic       ret_ld;
        logic       halted;
    } ctrl_t;

    // Opcodes that carry an operand byte and therefore need the S_F2 fetch.
    function automatic logic is_two_byte(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_JMP, OP_JZ: return 1'b1;
`ifdef RET_STACK_EN
            OP_JSR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_select_controller_if.sv
// One-hot select interface between the control FSM and the datapath.
// Modport master: the controller. It receives mem_ready, ir_op and acc_zero,
// and it drives every select, load, strobe and status signal.
// Modport slave: the datapath side, with the directions mirrored.
interface mc_select_controller_if;
    logic       mem_ready;
    logic [3:0] ir_op;
    logic       acc_zero;
    logic       pc_sel_inc;
    logic       pc_sel_jmp;
    logic       pc_sel_ret;
    logic       pc_ld;
    logic       addr_sel_pc;
    logic       addr_sel_ir;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_hi_ld;
    logic       ir_lo_ld;
    logic       mdr_ld;
    logic       acc_sel_alu;
    logic       acc_sel_mem;
    logic       acc_ld;
    logic [1:0] alu_op;
    logic       ret_ld;
    logic       halted;
    logic       bus_err;

    modport master (
        input  mem_ready, ir_op, acc_zero,
        output pc_sel_inc, pc_sel_jmp, pc_sel_ret, pc_ld, addr_sel_pc, addr_sel_ir,
               mem_rd, mem_wr, ir_hi_ld, ir_lo_ld, mdr_ld, acc_sel_alu, acc_sel_mem,
               acc_ld, alu_op, ret_ld, halted, bus_err
    );

    modport slave (
        output mem_ready, ir_op, acc_zero,
        input  pc_sel_inc, pc_sel_jmp, pc_sel_ret, pc_ld, addr_sel_pc, addr_sel_ir,
               mem_rd, mem_wr, ir_hi_ld, ir_lo_ld, mdr_ld, acc_sel_alu, acc_sel_mem,
               acc_ld, alu_op, ret_ld, halted, bus_err
    );
endinterface

// File: rtl/mc_select_controller_encoder.sv
// mc_select_encoder: purely combinational decode from (state, opcode, flags)
// to the control vector. Each select group has at most one bit set.
// Ports: state_i (FSM state), ir_op_i (opcode), mem_ready_i, acc_zero_i,
// and ctrl_o (select/enable vector).
// Optional feature macro: RET_STACK_EN (adds the JSR ret_ld and the S_RET decode).
module mc_select_encoder
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [3:0] ir_op_i,
    input  logic       mem_ready_i,
    input  logic       acc_zero_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_F1, S_F2: begin
                ctrl_o.addr_sel_pc = 1'b1;
                ctrl_o.mem_rd      = 1'b1;
                // Loads fire only in the completing cycle.
                if (mem_ready_i) begin
                    ctrl_o.ir_hi_ld   = (state_i == S_F1);
                    ctrl_o.ir_lo_ld   = (state_i == S_F2);
                    ctrl_o.pc_sel_inc = 1'b1;
                    ctrl_o.pc_ld      = 1'b1;
                end
            end
            S_RD: begin
                ctrl_o.addr_sel_ir = 1'b1;
                ctrl_o.mem_rd      = 1'b1;
                ctrl_o.mdr_ld      = mem_ready_i;
            end
            S_WR: begin
                ctrl_o.addr_sel_ir = 1'b1;
                ctrl_o.mem_wr      = 1'b1;
            end
            S_WB: begin
                ctrl_o.acc_ld = 1'b1;
                case (ir_op_i)
                    OP_LDA: ctrl_o.acc_sel_mem = 1'b1;
                    OP_ADD: begin ctrl_o.acc_sel_alu = 1'b1; ctrl_o.alu_op = ALU_ADD; end
                    OP_SUB: begin ctrl_o.acc_sel_alu = 1'b1; ctrl_o.alu_op = ALU_SUB; end
                    OP_AND: begin ctrl_o.acc_sel_alu = 1'b1; ctrl_o.alu_op = ALU_AND; end
                    OP_NOT: begin ctrl_o.acc_sel_alu = 1'b1; ctrl_o.alu_op = ALU_NOT; end
                    default: ctrl_o.acc_ld = 1'b0;
                endcase
            end
            S_JMP: begin
                // A JZ with acc_zero=0 falls through without touching the PC.
                if (ir_op_i != OP_JZ || acc_zero_i) begin
                    ctrl_o.pc_sel_jmp = 1'b1;
                    ctrl_o.pc_ld      = 1'b1;
                end
`ifdef RET_STACK_EN
                ctrl_o.ret_ld = (ir_op_i == OP_JSR);
`endif
            end
`ifdef RET_STACK_EN
            S_RET: begin
                ctrl_o.pc_sel_ret = 1'b1;
                ctrl_o.pc_ld      = 1'b1;
            end
`endif
            S_HALT: ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_select_controller.sv
// mc_select_controller: multicycle control FSM for the accumulator datapath.
// It produces the one-hot (onehot0) mux selects and the load/strobe enables.
// Ports: clk, rst_n (synchronous, active low), and bus (mc_select_controller_if.master).
// Parameter MEM_WAIT_MAX (1..255) is the number of consecutive mem_ready=0 cycles
// that a memory state tolerates before the controller raises the sticky bus_err
// and halts.
// Optional feature macro: RET_STACK_EN enables JSR/RET. When it is undefined,
// both opcodes act as NOP, and pc_sel_ret and ret_ld stay at 0.
module mc_select_controller
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mc_select_controller_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic       mem_st;
    ctrl_t      ctrl;

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        err_d   = err_q;
        mem_st  = 1'b0;
        case (state_q)
            S_RST: state_d = S_F1;
            S_F1: begin
                mem_st = 1'b1;
                if (bus.mem_ready) state_d = S_DEC;
            end
            S_DEC: begin
                case (bus.ir_op)
                    OP_NOP: state_d = S_F1;
                    OP_NOT: state_d = S_WB;
                    OP_HLT: state_d = S_HALT;
`ifdef RET_STACK_EN
                    OP_RET: state_d = S_RET;
`endif
                    default: state_d = is_two_byte(bus.ir_op) ? S_F2 : S_F1;
                endcase
            end
            S_F2: begin
                mem_st = 1'b1;
                if (bus.mem_ready) begin
                    case (bus.ir_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = S_RD;
                        OP_STA:                         state_d = S_WR;
                        default:                        state_d = S_JMP;
                    endcase
                end
            end
            S_RD: begin
                mem_st = 1'b1;
                if (bus.mem_ready) state_d = S_WB;
            end
            S_WR: begin
                mem_st = 1'b1;
                if (bus.mem_ready) state_d = S_F1;
            end
            S_WB, S_JMP: state_d = S_F1;
`ifdef RET_STACK_EN
            S_RET: state_d = S_F1;
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase

        // The wait counter only runs while a memory state stalls, and it
        // returns to zero whenever the access completes or the state changes.
        // If mem_ready=1 arrives in the last allowed cycle, the access still
        // completes normally.
        if (mem_st && !bus.mem_ready) begin
            if (wait_q == WAIT_LAST) begin
                err_d   = 1'b1;
                state_d = S_HALT;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RST;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    mc_select_encoder u_enc (
        .state_i     (state_q),
        .ir_op_i     (bus.ir_op),
        .mem_ready_i (bus.mem_ready),
        .acc_zero_i  (bus.acc_zero),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_sel_inc  = ctrl.pc_sel_inc;
    assign bus.pc_sel_jmp  = ctrl.pc_sel_jmp;
    assign bus.pc_sel_ret  = ctrl.pc_sel_ret;
    assign bus.pc_ld       = ctrl.pc_ld;
    assign bus.addr_sel_pc = ctrl.addr_sel_pc;
    assign bus.addr_sel_ir = ctrl.addr_sel_ir;
    assign bus.mem_rd      = ctrl.mem_rd;
    assign bus.mem_wr      = ctrl.mem_wr;
    assign bus.ir_hi_ld    = ctrl.ir_hi_ld;
    assign bus.ir_lo_ld    = ctrl.ir_lo_ld;
    assign bus.mdr_ld      = ctrl.mdr_ld;
    assign bus.acc_sel_alu = ctrl.acc_sel_alu;
    assign bus.acc_sel_mem = ctrl.acc_sel_mem;
    assign bus.acc_ld      = ctrl.acc_ld;
    assign bus.alu_op      = ctrl.alu_op;
    assign bus.ret_ld      = ctrl.ret_ld;
    assign bus.halted      = ctrl.halted;
    assign bus.bus_err     = err_q;

endmodule
